// File: rtl/kd_pkg.sv
// Shared types and widths for the keypad debouncer.
// The state enum is shared by the top-level FSM and any future observers.
package kd_pkg;
  localparam int CODE_W = 5;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    PRESSED    = 2'd2,
    DB_RELEASE = 2'd3
  } kd_state_t;
endpackage

// File: rtl/prio_enc.sv
// Combinational priority encoder: lowest-numbered asserted request wins.
// o_idx is zero when no request is asserted.
module prio_enc
  import kd_pkg::*;
#(
  parameter int WIDTH = 20
) (
  input  logic [WIDTH-1:0]  i_req,
  output logic              o_any,
  output logic [CODE_W-1:0] o_idx
);

  always_comb begin
    o_any = |i_req;
    o_idx = '0;
    // Scan downward so the lowest set bit is the last to write o_idx.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = CODE_W'(i);
    end
  end

endmodule

// File: rtl/keypad_debounce.sv
// Keypad debouncer: accepts one button press after DB_CYCLES stable samples,
// emits a one-cycle strobe per press and per auto-repeat, holds until a debounced release.
module keypad_debounce
  import kd_pkg::*;
#(
  parameter int WIDTH      = 20,
  parameter int DB_CYCLES  = 3,
  parameter int RPT_DELAY  = 50,
  parameter int RPT_PERIOD = 10
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [WIDTH-1:0]  sync_in,
  output logic [CODE_W-1:0] code,
  output logic              strobe,
  output logic              held
);

  localparam int DB_W    = $clog2(DB_CYCLES + 1);
  localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [DB_W-1:0]  DB_SAT     = DB_W'(DB_CYCLES);
  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DB_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_SAT    = RPT_W'(RPT_MAX);
  localparam logic [RPT_W-1:0] RPT_D_LAST = RPT_W'((RPT_DELAY > 0) ? RPT_DELAY - 1 : 0);
  localparam logic [RPT_W-1:0] RPT_P_LAST = RPT_W'((RPT_PERIOD > 0) ? RPT_PERIOD - 1 : 0);
  localparam bit               ONE_SHOT   = (DB_CYCLES <= 1);
  localparam bit               RPT_EN     = (RPT_DELAY > 0);

  logic              w_any;
  logic [CODE_W-1:0] w_idx;

  kd_state_t         r_state,  w_state_nxt;
  logic [DB_W-1:0]   r_cnt,    w_cnt_nxt;
  logic [CODE_W-1:0] r_cand,   w_cand_nxt;
  logic [CODE_W-1:0] r_code,   w_code_nxt;
  logic              r_strobe, w_strobe_nxt;
  logic              r_held,   w_held_nxt;
  logic [RPT_W-1:0]  r_rpt,    w_rpt_nxt;
  logic              r_rpt_ph, w_rpt_ph_nxt;

  logic [DB_W-1:0]   w_cnt_inc;
  logic [RPT_W-1:0]  w_rpt_inc;
  logic              w_db_done;
  logic              w_rpt_hit;

  prio_enc #(.WIDTH(WIDTH)) u_enc (
    .i_req (sync_in),
    .o_any (w_any),
    .o_idx (w_idx)
  );

  assign w_cnt_inc = (r_cnt >= DB_SAT)  ? r_cnt : r_cnt + DB_W'(1);
  assign w_rpt_inc = (r_rpt >= RPT_SAT) ? r_rpt : r_rpt + RPT_W'(1);
  assign w_db_done = (r_cnt >= DB_LAST);
  // Phase 0 waits out the initial delay, phase 1 runs the steady repeat period.
  assign w_rpt_hit = r_rpt_ph ? (r_rpt >= RPT_P_LAST) : (r_rpt >= RPT_D_LAST);

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_cand_nxt   = r_cand;
    w_code_nxt   = r_code;
    w_strobe_nxt = 1'b0;
    w_rpt_nxt    = r_rpt;
    w_rpt_ph_nxt = r_rpt_ph;

    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_cand_nxt = w_idx;
          if (ONE_SHOT) begin
            w_state_nxt  = PRESSED;
            w_code_nxt   = w_idx;
            w_strobe_nxt = 1'b1;
            w_rpt_nxt    = '0;
            w_rpt_ph_nxt = 1'b0;
            w_cnt_nxt    = '0;
          end else begin
            w_state_nxt = DB_PRESS;
            w_cnt_nxt   = DB_W'(1);
          end
        end
      end
      DB_PRESS: begin
        if (!w_any) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (w_idx != r_cand) begin
          w_cand_nxt = w_idx;
          w_cnt_nxt  = DB_W'(1);
        end else if (w_db_done) begin
          w_state_nxt  = PRESSED;
          w_code_nxt   = r_cand;
          w_strobe_nxt = 1'b1;
          w_rpt_nxt    = '0;
          w_rpt_ph_nxt = 1'b0;
          w_cnt_nxt    = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      PRESSED: begin
        if (!w_any) begin
          w_state_nxt = ONE_SHOT ? IDLE : DB_RELEASE;
          w_cnt_nxt   = ONE_SHOT ? '0 : DB_W'(1);
        end else if (RPT_EN) begin
          if (w_rpt_hit) begin
            w_rpt_nxt    = '0;
            w_rpt_ph_nxt = 1'b1;
            // Guard keeps strobe from ever running two cycles back to back.
            w_strobe_nxt = !r_strobe;
          end else begin
            w_rpt_nxt = w_rpt_inc;
          end
        end
      end
      DB_RELEASE: begin
        if (w_any) begin
          w_state_nxt  = PRESSED;
          w_rpt_nxt    = '0;
          w_rpt_ph_nxt = 1'b0;
          w_cnt_nxt    = '0;
        end else if (w_db_done) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    w_held_nxt = (w_state_nxt == PRESSED) || (w_state_nxt == DB_RELEASE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_cand   <= '0;
      r_code   <= '0;
      r_strobe <= 1'b0;
      r_held   <= 1'b0;
      r_rpt    <= '0;
      r_rpt_ph <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_cand   <= w_cand_nxt;
      r_code   <= w_code_nxt;
      r_strobe <= w_strobe_nxt;
      r_held   <= w_held_nxt;
      r_rpt    <= w_rpt_nxt;
      r_rpt_ph <= w_rpt_ph_nxt;
    end
  end

  assign code   = r_code;
  assign strobe = r_strobe;
  assign held   = r_held;

endmodule

// File: tb/tb_keypad_debounce.sv
// Directed bench for keypad_debounce with WIDTH=20, DB_CYCLES=3, RPT_DELAY=10, RPT_PERIOD=4.
module tb_keypad_debounce;
  import kd_pkg::*;

  logic              clk;
  logic              n_rst;
  logic [19:0]       sync_in;
  logic [CODE_W-1:0] code;
  logic              strobe;
  logic              held;

  int n_cmp;
  int n_err;

  keypad_debounce #(
    .WIDTH      (20),
    .DB_CYCLES  (3),
    .RPT_DELAY  (10),
    .RPT_PERIOD (4)
  ) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .sync_in (sync_in),
    .code    (code),
    .strobe  (strobe),
    .held    (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then sample strobe and held just after it.
  task automatic tick(input logic exp_s, input logic exp_h, input string tag);
    @(posedge clk);
    #1;
    chk({tag, ".strobe"}, {31'd0, strobe}, {31'd0, exp_s});
    chk({tag, ".held"},   {31'd0, held},   {31'd0, exp_h});
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    n_rst   = 1'b0;
    sync_in = '0;

    #3;
    chk("reset.code",   {27'd0, code},   32'd0);
    chk("reset.strobe", {31'd0, strobe}, 32'd0);
    chk("reset.held",   {31'd0, held},   32'd0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    tick(1'b0, 1'b0, "idle");

    // Clean press on bit 5, 8 edges, then release.
    sync_in = 20'h00020;
    for (int e = 1; e <= 8; e++) begin
      tick(e == 3, e >= 3, "clean");
      if (e >= 3) chk("clean.code", {27'd0, code}, 32'd5);
    end
    sync_in = '0;
    for (int e = 1; e <= 3; e++) tick(1'b0, e < 3, "clean_rel");
    chk("clean_rel.code", {27'd0, code}, 32'd5);

    // Bounce: high 2, low 1, high 4.
    sync_in = 20'h00020;
    for (int e = 1; e <= 2; e++) tick(1'b0, 1'b0, "bounce_a");
    sync_in = '0;
    tick(1'b0, 1'b0, "bounce_gap");
    sync_in = 20'h00020;
    for (int e = 1; e <= 4; e++) tick(e == 3, e >= 3, "bounce_b");
    sync_in = '0;
    for (int e = 1; e <= 3; e++) tick(1'b0, e < 3, "bounce_rel");

    // Simultaneous bits 3 and 7.
    sync_in = 20'h00088;
    for (int e = 1; e <= 5; e++) begin
      tick(e == 3, e >= 3, "simul");
      if (e >= 3) chk("simul.code", {27'd0, code}, 32'd3);
    end
    sync_in = '0;
    for (int e = 1; e <= 3; e++) tick(1'b0, e < 3, "simul_rel");

    // Auto-repeat: bit 2 held 30 edges.
    sync_in = 20'h00004;
    for (int e = 1; e <= 30; e++) begin
      tick((e == 3) || (e == 13) || (e == 17) || (e == 21) || (e == 25) || (e == 29),
           e >= 3, "repeat");
      if (e >= 3) chk("repeat.code", {27'd0, code}, 32'd2);
    end
    sync_in = '0;
    for (int e = 1; e <= 3; e++) tick(1'b0, e < 3, "repeat_rel");

    // Encoding change while pressed, then release glitch.
    sync_in = 20'h00200;
    for (int e = 1; e <= 4; e++) tick(e == 3, e >= 3, "glitch_press");
    chk("glitch_press.code", {27'd0, code}, 32'd9);
    sync_in = 20'h00202;
    for (int e = 1; e <= 2; e++) tick(1'b0, 1'b1, "enc_change");
    chk("enc_change.code", {27'd0, code}, 32'd9);
    sync_in = '0;
    for (int e = 1; e <= 2; e++) tick(1'b0, 1'b1, "glitch_low");
    sync_in = 20'h00200;
    for (int e = 1; e <= 3; e++) tick(1'b0, 1'b1, "glitch_back");
    chk("glitch_back.code", {27'd0, code}, 32'd9);
    sync_in = '0;
    for (int e = 1; e <= 3; e++) tick(1'b0, e < 3, "glitch_rel");
    chk("glitch_rel.code", {27'd0, code}, 32'd9);

    // Reset while debouncing bit 4 (cnt=2), button kept held.
    sync_in = 20'h00010;
    for (int e = 1; e <= 2; e++) tick(1'b0, 1'b0, "rst_db");
    n_rst = 1'b0;
    #1;
    chk("rst_mid.code",   {27'd0, code},   32'd0);
    chk("rst_mid.strobe", {31'd0, strobe}, 32'd0);
    chk("rst_mid.held",   {31'd0, held},   32'd0);
    for (int e = 1; e <= 2; e++) tick(1'b0, 1'b0, "rst_hold");
    n_rst = 1'b1;
    for (int e = 1; e <= 4; e++) tick(e == 3, e >= 3, "rst_after");
    chk("rst_after.code", {27'd0, code}, 32'd4);
    sync_in = '0;
    for (int e = 1; e <= 3; e++) tick(1'b0, e < 3, "rst_rel");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/keypad_debounce.md
KEYPAD_DEBOUNCE -- requirements
Module: keypad_debounce

Interface
REQ-001 SHALL have parameter WIDTH, default 20: number of synchronized button inputs, legal range 1..32.
REQ-002 SHALL have parameter DB_CYCLES, default 3: consecutive stable samples required to accept a press or a release, at least 1.
REQ-003 SHALL have parameter RPT_DELAY, default 50: cycles in PRESSED before the first auto-repeat strobe; 0 disables auto-repeat.
REQ-004 SHALL have parameter RPT_PERIOD, default 10: cycles between later auto-repeat strobes, at least 1.
REQ-005 clk  input  1  system clock (hz100); all state updates on posedge clk.
REQ-006 n_rst  input  1  reset, asynchronous, active-low.
REQ-007 sync_in  input  WIDTH  button levels, already two-stage synchronized upstream, active-high.
REQ-008 code  output  5  index of the accepted button, registered.
REQ-009 strobe  output  1  one-cycle pulse per accepted press or auto-repeat, registered.
REQ-010 held  output  1  high while a press is accepted and not yet released, registered.

Function
REQ-011 The encoder SHALL select the lowest-numbered asserted bit of sync_in; any_press means at least one bit of sync_in is high.
REQ-012 The FSM SHALL have four states: IDLE, DB_PRESS, PRESSED, DB_RELEASE.
REQ-013 IDLE: on any_press SHALL go to DB_PRESS, set cnt=1, and latch the encoded index as the candidate.
REQ-014 DB_PRESS, no press: SHALL return to IDLE.
REQ-015 DB_PRESS, encoded index differs from the candidate: SHALL reload the candidate and set cnt=1.
REQ-016 DB_PRESS, same index: SHALL increment cnt.
REQ-017 DB_PRESS, index stable for DB_CYCLES samples: at the DB_CYCLES-th sampling edge SHALL enter PRESSED, load code=candidate, and assert strobe for exactly the following cycle.
REQ-018 PRESSED: held=1; an encoding change while any_press stays high SHALL be ignored (no new strobe, code unchanged).
REQ-019 PRESSED with RPT_DELAY>0: SHALL pulse strobe RPT_DELAY cycles after entry, then every RPT_PERIOD cycles while PRESSED; code unchanged.
REQ-020 PRESSED, no press: SHALL go to DB_RELEASE with cnt=1; the repeat timer stops.
REQ-021 DB_RELEASE, any_press again: SHALL return to PRESSED without a strobe, restarting the repeat timer from zero.
REQ-022 DB_RELEASE, no press for DB_CYCLES consecutive samples: SHALL go to IDLE and drop held; code SHALL retain its last value.
REQ-023 strobe SHALL never be high for two consecutive cycles; the press strobe and a repeat strobe SHALL never coincide.
REQ-024 Counters SHALL be sized with $clog2 of their maximum count plus 1 and SHALL saturate, never wrap.

Reset
REQ-025 On n_rst low, SHALL go asynchronously to IDLE with code=0, strobe=0, held=0 and all counters and the candidate cleared.
REQ-026 A reset in any state SHALL discard the debounce in progress; a button still held after reset SHALL need a full DB_CYCLES debounce before its strobe.

Structure
REQ-027 Package kd_pkg SHALL hold the state enum typedef (kd_state_t) and the localparam CODE_W=5.
REQ-028 The priority encoder SHALL be a separate combinational sub-module, prio_enc, parameterized by WIDTH.
REQ-029 Outputs SHALL be driven from flops only; sync_in SHALL reach no output through a combinational path.

Verification (WIDTH=20, DB_CYCLES=3, RPT_DELAY=10, RPT_PERIOD=4)
REQ-030 Clean press: sync_in[5] high for 8 edges, then low -> one strobe after edge 3, code=5, held falls 3 edges after release.
REQ-031 Bounce: bit 5 high 2 edges, low 1, high 4 -> no strobe during the bounce; one strobe after the 3rd edge of the final high run.
REQ-032 Simultaneous: bits 3 and 7 high together for 5 edges -> code=3 and one strobe.
REQ-033 Auto-repeat: bit 2 held 30 edges -> strobes after edges 3, 13, 17, 21, 25 and 29, code=2 throughout.
REQ-034 Release glitch: press accepted, sync_in zero for 2 edges, then high again -> no new strobe, held stays 1.
REQ-035 Reset mid-DB_PRESS (cnt=2): code, strobe and held are 0 immediately; with the button still held after reset deasserts, strobe comes 3 edges later.
